// File: rtl/dmem_arbiter_rv32i.sv
// Core/DMA arbiter for a single-ported RV32I data memory.
// Each granted request gets one memory cycle and then a one-cycle response pulse.
module dmem_arbiter_rv32i #(
  parameter int MAX_BURST = 4,
  parameter int WORD_AW   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req_valid,
  output logic        c_req_ready,
  input  logic        c_we,
  input  logic [1:0]  c_storetype,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic        c_rsp_valid,
  output logic [31:0] c_rsp_data,
  output logic        c_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [1:0]  d_storetype,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err,
  input  logic        d_lock,
  output logic        mem_we,
  output logic [1:0]  mem_storetype,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        last_d_q;
  logic [3:0]  burst_q;
  logic        owner_d_q, we_q, err_q;
  logic        mem_we_q;
  logic [1:0]  mem_storetype_q;
  logic [31:0] mem_addr_q, mem_wdata_q;
  logic        c_rsp_valid_q, c_rsp_err_q, d_rsp_valid_q, d_rsp_err_q;
  logic [31:0] c_rsp_data_q, d_rsp_data_q;

  logic        grant_c_s, grant_d_s, lock_win_s;
  logic        sel_we_s, sel_err_s;
  logic [1:0]  sel_st_s;
  logic [31:0] sel_addr_s, sel_wdata_s, rsp_word_s;

  // Loads skip only the storetype=11 check; range and halfword/word alignment apply to both.
  function automatic logic req_error(input logic we, input logic [1:0] st, input logic [31:0] addr);
    logic out_of_range;
    logic misaligned;
    out_of_range = (addr >> (WORD_AW + 2)) != 32'd0;
    case (st)
      2'b01:   misaligned = addr[0];
      2'b10:   misaligned = (addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return out_of_range | misaligned | (we & (st == 2'b11));
  endfunction

  assign lock_win_s = d_lock && last_d_q && (burst_q < 4'(MAX_BURST));

  always_comb begin
    state_d   = state_q;
    grant_c_s = 1'b0;
    grant_d_s = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (c_req_valid && d_req_valid) begin
          if (lock_win_s) begin
            grant_d_s = 1'b1;
          end else if (last_d_q) begin
            grant_c_s = 1'b1;
          end else begin
            grant_d_s = 1'b1;
          end
        end else begin
          grant_c_s = c_req_valid;
          grant_d_s = d_req_valid;
        end
        if (grant_c_s || grant_d_s) begin
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: state_d = ST_RESP;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    if (grant_d_s) begin
      sel_we_s    = d_we;
      sel_st_s    = d_storetype;
      sel_addr_s  = d_addr;
      sel_wdata_s = d_wdata;
    end else begin
      sel_we_s    = c_we;
      sel_st_s    = c_storetype;
      sel_addr_s  = c_addr;
      sel_wdata_s = c_wdata;
    end
    sel_err_s = req_error(sel_we_s, sel_st_s, sel_addr_s);
  end

  assign rsp_word_s = (we_q || err_q) ? 32'd0 : mem_rdata;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      last_d_q  <= 1'b1;
      burst_q   <= 4'd0;
      owner_d_q <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_c_s || grant_d_s) begin
        owner_d_q <= grant_d_s;
        we_q      <= sel_we_s;
        err_q     <= sel_err_s;
        last_d_q  <= grant_d_s;
      end else begin
        owner_d_q <= owner_d_q;
        we_q      <= we_q;
        err_q     <= err_q;
        last_d_q  <= last_d_q;
      end
      // Burst only counts consecutive DMA grants while the lock is held.
      if (grant_c_s || !d_lock) begin
        burst_q <= 4'd0;
      end else if (grant_d_s && (burst_q < 4'(MAX_BURST))) begin
        burst_q <= burst_q + 4'd1;
      end else begin
        burst_q <= burst_q;
      end
    end
  end

  // Memory port is loaded at grant so it is live for exactly the ACCESS cycle.
  always_ff @(posedge clock) begin
    if (reset || !(grant_c_s || grant_d_s)) begin
      mem_we_q        <= 1'b0;
      mem_storetype_q <= 2'b00;
      mem_addr_q      <= 32'd0;
      mem_wdata_q     <= 32'd0;
    end else begin
      mem_we_q        <= sel_we_s & ~sel_err_s;
      mem_storetype_q <= sel_st_s;
      mem_addr_q      <= sel_addr_s;
      mem_wdata_q     <= sel_wdata_s;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || (state_q != ST_ACCESS)) begin
      c_rsp_valid_q <= 1'b0;
      c_rsp_err_q   <= 1'b0;
      c_rsp_data_q  <= 32'd0;
      d_rsp_valid_q <= 1'b0;
      d_rsp_err_q   <= 1'b0;
      d_rsp_data_q  <= 32'd0;
    end else begin
      c_rsp_valid_q <= ~owner_d_q;
      c_rsp_err_q   <= ~owner_d_q & err_q;
      c_rsp_data_q  <= owner_d_q ? 32'd0 : rsp_word_s;
      d_rsp_valid_q <= owner_d_q;
      d_rsp_err_q   <= owner_d_q & err_q;
      d_rsp_data_q  <= owner_d_q ? rsp_word_s : 32'd0;
    end
  end

  assign c_req_ready   = grant_c_s & ~reset;
  assign d_req_ready   = grant_d_s & ~reset;
  assign mem_we        = mem_we_q;
  assign mem_storetype = mem_storetype_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign c_rsp_valid   = c_rsp_valid_q;
  assign c_rsp_data    = c_rsp_data_q;
  assign c_rsp_err     = c_rsp_err_q;
  assign d_rsp_valid   = d_rsp_valid_q;
  assign d_rsp_data    = d_rsp_data_q;
  assign d_rsp_err     = d_rsp_err_q;

endmodule

// File: tb/tb_dmem_arbiter_rv32i.sv
// Bench for dmem_arbiter_rv32i: directed scenarios plus a randomized run against a
// transaction-level model (grant slots, per-request schedule, shadow memory).
module tb_dmem_arbiter_rv32i;
  localparam int MAXB = 4;

  logic clock = 1'b0;
  logic reset;
  logic c_req_valid, c_req_ready, c_we, c_rsp_valid, c_rsp_err;
  logic [1:0] c_storetype;
  logic [31:0] c_addr, c_wdata, c_rsp_data;
  logic d_req_valid, d_req_ready, d_we, d_rsp_valid, d_rsp_err, d_lock;
  logic [1:0] d_storetype;
  logic [31:0] d_addr, d_wdata, d_rsp_data;
  logic mem_we;
  logic [1:0] mem_storetype;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  dmem_arbiter_rv32i #(.MAX_BURST(MAXB), .WORD_AW(8)) dut (
    .clock(clock), .reset(reset),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_we(c_we),
    .c_storetype(c_storetype), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_data(c_rsp_data), .c_rsp_err(c_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_we(d_we),
    .d_storetype(d_storetype), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err),
    .d_lock(d_lock),
    .mem_we(mem_we), .mem_storetype(mem_storetype), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] st,
                                        input logic [31:0] addr, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (st)
      2'b00:   r[{addr[1:0], 3'b000} +: 8] = wd[7:0];
      2'b01:   r[{addr[1], 4'b0000} +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Environment memory: 256 words, asynchronous read, byte/half/word write.
  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clock) begin
    if (mem_we === 1'b1) mem[mem_addr[9:2]] <= merge(mem[mem_addr[9:2]], mem_storetype, mem_addr, mem_wdata);
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic bit is_bad(input logic we, input logic [1:0] st, input logic [31:0] addr);
    if (addr >= 32'h0000_0400) return 1'b1;
    if (st == 2'b01 && addr[0]) return 1'b1;
    if (st == 2'b10 && addr[1:0] != 2'b00) return 1'b1;
    return we && (st == 2'b11);
  endfunction

  function automatic logic [31:0] rand_addr(input logic [1:0] st);
    logic [31:0] a;
    a = 32'($urandom_range(0, 1023));
    if ($urandom_range(0, 9) == 0) begin
      a = 32'h0000_0400 + 32'($urandom_range(0, 4095));
    end else if ($urandom_range(0, 3) != 0) begin
      if (st == 2'b10) a[1:0] = 2'b00;
      if (st == 2'b01) a[0] = 1'b0;
    end
    return a;
  endfunction

  task automatic set_core(input logic v, input logic we, input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd);
    c_req_valid = v; c_we = we; c_storetype = st; c_addr = a; c_wdata = wd;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd);
    d_req_valid = v; d_we = we; d_storetype = st; d_addr = a; d_wdata = wd;
  endtask

  task automatic idle_all();
    set_core(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    set_dma(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_all();
    d_lock = 1'b0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  // Issues one request on a single port and records what each of its three cycles shows.
  task automatic txn(input bit dma, input logic we, input logic [1:0] st, input logic [31:0] a, input logic [31:0] wd,
                     output logic rdy, output logic erv, output logic mwe, output logic [31:0] ma,
                     output logic [31:0] mw, output logic [1:0] ms, output logic rv,
                     output logic [31:0] rd, output logic re, output logic orv);
    step();
    if (dma) set_dma(1'b1, we, st, a, wd); else set_core(1'b1, we, st, a, wd);
    sample();
    rdy = dma ? d_req_ready : c_req_ready;
    step();
    idle_all();
    sample();
    erv = dma ? d_rsp_valid : c_rsp_valid;
    mwe = mem_we; ma = mem_addr; mw = mem_wdata; ms = mem_storetype;
    step();
    sample();
    rv  = dma ? d_rsp_valid : c_rsp_valid;
    rd  = dma ? d_rsp_data : c_rsp_data;
    re  = dma ? d_rsp_err : c_rsp_err;
    orv = dma ? c_rsp_valid : d_rsp_valid;
  endtask

  task automatic test_reset();
    set_core(1'b1, 1'b0, 2'b10, 32'h0, 32'h0);
    set_dma(1'b1, 1'b0, 2'b10, 32'h4, 32'h0);
    step();
    sample();
    checks++;
    if ({c_req_ready, d_req_ready, mem_we, c_rsp_valid, d_rsp_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_hold: got %b expected 00000", {c_req_ready, d_req_ready, mem_we, c_rsp_valid, d_rsp_valid});
    end
    step();
    reset = 1'b0;
    idle_all();
    sample();
    checks++;
    if ({mem_we, mem_storetype, mem_addr, mem_wdata, c_rsp_data, d_rsp_data, c_rsp_err, d_rsp_err} !== 101'd0) begin
      errors++; $display("FAIL reset_outputs: mem_addr=%h mem_wdata=%h mem_we=%b expected all zero", mem_addr, mem_wdata, mem_we);
    end
  endtask

  task automatic test_store();
    logic rdy, erv, mwe, rv, re, orv;
    logic [31:0] ma, mw, rd;
    logic [1:0] ms;
    txn(1'b0, 1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL store_ready: got %b expected 1", rdy); end
    checks++; if ({erv, mwe, ms} !== 4'b0110) begin errors++; $display("FAIL store_access: got rv=%b we=%b st=%b expected rv=0 we=1 st=10", erv, mwe, ms); end
    checks++; if ({ma, mw} !== {32'h10, 32'hDEADBEEF}) begin errors++; $display("FAIL store_bus: got addr=%h data=%h expected 00000010 deadbeef", ma, mw); end
    checks++; if ({rv, re, rd, orv} !== {1'b1, 1'b0, 32'd0, 1'b0}) begin errors++; $display("FAIL store_rsp: got v=%b e=%b d=%h other=%b expected 1 0 0 0", rv, re, rd, orv); end
    txn(1'b0, 1'b0, 2'b10, 32'h10, 32'h0, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if ({rv, re, rd, mwe} !== {1'b1, 1'b0, 32'hDEADBEEF, 1'b0}) begin errors++; $display("FAIL store_readback: got v=%b e=%b d=%h we=%b expected 1 0 deadbeef 0", rv, re, rd, mwe); end
  endtask

  task automatic test_errors();
    logic rdy, erv, mwe, rv, re, orv;
    logic [31:0] ma, mw, rd;
    logic [1:0] ms;
    txn(1'b0, 1'b1, 2'b01, 32'h13, 32'h1234, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if ({rdy, mwe, rv, re, rd} !== {4'b1011, 32'd0}) begin errors++; $display("FAIL err_sh_misaligned: got rdy=%b we=%b v=%b e=%b d=%h expected 1 0 1 1 0", rdy, mwe, rv, re, rd); end
    txn(1'b1, 1'b1, 2'b00, 32'h400, 32'hFF, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if ({rdy, mwe, rv, re, rd, orv} !== {4'b1011, 32'd0, 1'b0}) begin errors++; $display("FAIL err_sb_range: got rdy=%b we=%b v=%b e=%b d=%h other=%b expected 1 0 1 1 0 0", rdy, mwe, rv, re, rd, orv); end
    txn(1'b0, 1'b0, 2'b11, 32'h13, 32'h0, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if ({rv, re, rd} !== {2'b10, 32'hDEADBEEF}) begin errors++; $display("FAIL err_load_type11: got v=%b e=%b d=%h expected 1 0 deadbeef", rv, re, rd); end
    txn(1'b1, 1'b0, 2'b10, 32'h12, 32'h0, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if ({rv, re, rd} !== {2'b11, 32'd0}) begin errors++; $display("FAIL err_lw_misaligned: got v=%b e=%b d=%h expected 1 1 0", rv, re, rd); end
    txn(1'b1, 1'b1, 2'b11, 32'h20, 32'h77, rdy, erv, mwe, ma, mw, ms, rv, rd, re, orv);
    checks++; if ({mwe, rv, re} !== 3'b011) begin errors++; $display("FAIL err_store_type11: got we=%b v=%b e=%b expected 0 1 1", mwe, rv, re); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_core(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    for (int k = 0; k < 10; k++) begin
      logic [1:0] e_rdy, e_rsp;
      sample();
      e_rdy = {(k % 4) == 0, (k % 4) == 2};
      e_rsp = {(k >= 2) && ((k - 2) % 4 == 0), (k >= 2) && ((k - 2) % 4 == 2)};
      checks++;
      if ({c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid} !== {e_rdy, e_rsp}) begin
        errors++; $display("FAIL rr_slot%0d: got rdy=%b%b rsp=%b%b expected rdy=%b rsp=%b", k, c_req_ready, d_req_ready, c_rsp_valid, d_rsp_valid, e_rdy, e_rsp);
      end
      if (e_rsp != 2'b00) begin
        checks++;
        if ({c_rsp_data, d_rsp_data} !== (e_rsp[1] ? {32'hDEADBEEF, 32'd0} : {32'd0, init_word(8)})) begin
          errors++; $display("FAIL rr_data%0d: got c=%h d=%h", k, c_rsp_data, d_rsp_data);
        end
      end
      step();
    end
    idle_all();
  endtask

  task automatic test_lock_burst();
    bit exp_d [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    set_core(1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
    set_dma(1'b1, 1'b0, 2'b10, 32'h20, 32'h0);
    for (int j = 0; j < 11; j++) begin
      sample();
      checks++;
      if ({c_req_ready, d_req_ready} !== {~exp_d[j], exp_d[j]}) begin
        errors++; $display("FAIL lock_slot%0d: got c=%b d=%b expected c=%b d=%b", j, c_req_ready, d_req_ready, ~exp_d[j], exp_d[j]);
      end
      step();
      if (j == 0) d_lock = 1'b1;
      sample();
      checks++;
      if ({c_req_ready, d_req_ready} !== 2'b00) begin
        errors++; $display("FAIL lock_gap%0d: got %b%b expected 00", j, c_req_ready, d_req_ready);
      end
      step();
    end
    d_lock = 1'b0;
    idle_all();
  endtask

  task automatic test_reset_in_access();
    step();
    set_dma(1'b1, 1'b1, 2'b10, 32'h40, 32'hCAFEF00D);
    sample();
    checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL abort_grant: got %b expected 1", d_req_ready); end
    step();
    reset = 1'b1;
    idle_all();
    sample();
    checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL abort_access: got mem_we=%b expected 1", mem_we); end
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      sample();
      checks++;
      if ({d_rsp_valid, c_rsp_valid, mem_we, mem_addr, mem_wdata, c_req_ready, d_req_ready} !== 69'd0) begin
        errors++; $display("FAIL abort_quiet%0d: got drsp=%b mem_we=%b mem_addr=%h expected zeros", k, d_rsp_valid, mem_we, mem_addr);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [31:0] ref_mem [0:255];
    int next_free = 0;
    int burst = 0;
    bit last_d = 1'b1;
    bit rec_v = 1'b0;
    int acc_at = 0, rsp_at = 0;
    bit r_port, r_we, r_err;
    logic [1:0] r_st;
    logic [31:0] r_addr, r_wdata, r_data;
    bit c_pend = 1'b0, d_pend = 1'b0, c_gr = 1'b0, d_gr = 1'b0;
    do_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bit ec, ed, e_mwe;
      logic [6:0] e_ctl;
      logic [65:0] e_bus;
      logic [31:0] e_cd, e_dd;
      logic [1:0] st;
      if (c_gr) c_pend = 1'b0;
      if (c_pend && $urandom_range(0, 11) == 0) begin
        c_pend = 1'b0; c_req_valid = 1'b0;
      end else if (!c_pend && $urandom_range(0, 2) == 0) begin
        st = 2'($urandom_range(0, 3));
        set_core(1'b1, 1'($urandom_range(0, 1)), st, rand_addr(st), $urandom);
        c_pend = 1'b1;
      end else begin
        c_req_valid = c_pend;
      end
      if (d_gr) d_pend = 1'b0;
      if (d_pend && $urandom_range(0, 11) == 0) begin
        d_pend = 1'b0; d_req_valid = 1'b0;
      end else if (!d_pend && $urandom_range(0, 1) == 0) begin
        st = 2'($urandom_range(0, 3));
        set_dma(1'b1, 1'($urandom_range(0, 1)), st, rand_addr(st), $urandom);
        d_pend = 1'b1;
      end else begin
        d_req_valid = d_pend;
      end
      if ($urandom_range(0, 9) == 0) d_lock = ~d_lock;
      sample();
      ec = 1'b0; ed = 1'b0;
      if (cyc >= next_free) begin
        if (c_req_valid && d_req_valid) begin
          if (d_lock && last_d && burst < MAXB) ed = 1'b1;
          else if (last_d) ec = 1'b1;
          else ed = 1'b1;
        end else begin
          ec = c_req_valid; ed = d_req_valid;
        end
      end
      e_mwe = 1'b0; e_bus = 66'd0; e_cd = 32'd0; e_dd = 32'd0;
      e_ctl = {ec, ed, 5'b00000};
      if (rec_v && cyc == acc_at) begin
        e_mwe = r_we && !r_err;
        e_bus = {r_st, r_addr, r_wdata};
      end
      e_ctl[4] = e_mwe;
      if (rec_v && cyc == rsp_at) begin
        e_ctl[3:0] = r_port ? {2'b00, 1'b1, r_err} : {1'b1, r_err, 2'b00};
        if (r_port) e_dd = r_data; else e_cd = r_data;
      end
      checks++;
      if ({c_req_ready, d_req_ready, mem_we, c_rsp_valid, c_rsp_err, d_rsp_valid, d_rsp_err} !== e_ctl) begin
        errors++; if (errors < 30) $display("FAIL rnd_ctl cyc=%0d: got %b expected %b", cyc, {c_req_ready, d_req_ready, mem_we, c_rsp_valid, c_rsp_err, d_rsp_valid, d_rsp_err}, e_ctl);
      end
      checks++;
      if ({mem_storetype, mem_addr, mem_wdata} !== e_bus) begin
        errors++; if (errors < 30) $display("FAIL rnd_bus cyc=%0d: got %h expected %h", cyc, {mem_storetype, mem_addr, mem_wdata}, e_bus);
      end
      checks++;
      if ({c_rsp_data, d_rsp_data} !== {e_cd, e_dd}) begin
        errors++; if (errors < 30) $display("FAIL rnd_data cyc=%0d: got c=%h d=%h expected c=%h d=%h", cyc, c_rsp_data, d_rsp_data, e_cd, e_dd);
      end
      if (ec || ed) begin
        r_port  = ed;
        r_we    = ed ? d_we : c_we;
        r_st    = ed ? d_storetype : c_storetype;
        r_addr  = ed ? d_addr : c_addr;
        r_wdata = ed ? d_wdata : c_wdata;
        r_err   = is_bad(r_we, r_st, r_addr);
        r_data  = (r_we || r_err) ? 32'd0 : ref_mem[r_addr[9:2]];
        if (r_we && !r_err) ref_mem[r_addr[9:2]] = merge(ref_mem[r_addr[9:2]], r_st, r_addr, r_wdata);
        rec_v = 1'b1; acc_at = cyc + 1; rsp_at = cyc + 2; next_free = cyc + 2;
        last_d = ed;
      end
      if (ec || !d_lock) burst = 0;
      else if (ed) burst++;
      c_gr = ec; d_gr = ed;
      step();
    end
    idle_all();
    d_lock = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    d_lock = 1'b0;
    idle_all();
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    test_reset();
    test_store();
    test_errors();
    test_round_robin();
    test_lock_burst();
    test_reset_in_access();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter_rv32i.md
DMEM_ARBITER_RV32I -- requirements
Module: dmem_arbiter_rv32i

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, max consecutive DMA grants under lock while core waits (1..15).
REQ-002 SHALL have parameter WORD_AW, default 8, data-memory word-address width; valid byte addresses are 0 .. 2^(WORD_AW+2)-1.
REQ-003 SHALL run on one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 c_req_valid  in  1  core request pending; held with fields stable until c_req_ready.
REQ-007 c_req_ready  out  1  core request accepted this cycle.
REQ-008 c_we, c_storetype, c_addr, c_wdata  in  1/2/32/32  core write-enable, 00=SB 01=SH 10=SW, byte address, store data (LSB-aligned).
REQ-009 c_rsp_valid  out  1  one-cycle core response pulse.
REQ-010 c_rsp_data  out  32  raw memory word for loads; 0 for stores or on error.
REQ-011 c_rsp_err  out  1  request rejected (range/alignment/type).
REQ-012 d_req_valid, d_req_ready, d_we, d_storetype, d_addr, d_wdata, d_rsp_valid, d_rsp_data, d_rsp_err  same widths, directions and meanings as core, for DMA/debug loader.
REQ-013 d_lock  in  1  DMA requests burst priority.
REQ-014 mem_we  out  1  write enable to data memory.
REQ-015 mem_storetype  out  2  store type to data memory.
REQ-016 mem_addr  out  32  byte address to data memory.
REQ-017 mem_wdata  out  32  store data to data memory.
REQ-018 mem_rdata  in  32  asynchronous read word from data memory.

Function
REQ-019 SHALL implement FSM IDLE, ACCESS, RESP.
REQ-020 IDLE or RESP: if any req_valid, assert ready to exactly one winner, latch its fields, go ACCESS; else go IDLE.
REQ-021 ACCESS: drive mem_* from latched request for exactly one cycle; capture mem_rdata at clock edge; go RESP.
REQ-022 RESP: pulse winner's rsp_valid with captured data/err; the other port's rsp outputs stay 0.
REQ-023 Latency: request accepted at cycle N produces rsp_valid at N+2; back-to-back throughput is one access per 2 cycles.
REQ-024 Outside ACCESS: mem_we=0, mem_addr, mem_wdata, mem_storetype=0.
REQ-025 Arbitration with both valid and no lock: round-robin, the port not granted last wins.
REQ-026 Lock: d_lock=1, DMA granted last, burst count < MAX_BURST -> DMA wins; count increments per DMA grant.
REQ-027 Burst count resets to 0 on any core grant or when d_lock=0; at MAX_BURST with core valid, core wins.
REQ-028 Error if addr >= 2^(WORD_AW+2), SH with addr[0]=1, SW with addr[1:0]!=0, or we=1 with storetype=11.
REQ-029 Error access: mem_we forced 0, rsp_err=1, rsp_data=0; still takes the full 2-cycle latency.
REQ-030 Loads (we=0) ignore storetype for the error check, except range and alignment of addr[1:0] per storetype 01/10.
REQ-031 Request deasserted before ready SHALL be dropped silently, with no access.

Reset
REQ-032 Reset SHALL force IDLE, all ready/rsp/mem outputs 0, burst count 0, last-grant=DMA (core wins first tie).
REQ-033 Reset in ACCESS SHALL abort: mem_we low the following cycle, no rsp_valid issued.

Verification
REQ-034 Core SW addr 0x10 data 0xDEADBEEF at N -> c_req_ready at N, mem_we=1 mem_addr=0x10 at N+1, c_rsp_valid at N+2 err=0.
REQ-035 Both valid from reset, continuous loads -> grants C,D,C,D; each rsp_valid 2 cycles after its grant.
REQ-036 d_lock=1, both valid, MAX_BURST=4 -> after first core grant: D,D,D,D,C,D,...
REQ-037 Core SH addr 0x13 -> c_rsp_err=1, mem_we stays 0; DMA SB addr 0x400 (WORD_AW=8) -> d_rsp_err=1.
REQ-038 Reset asserted during ACCESS of a DMA write -> no rsp pulse, FSM IDLE, outputs 0 next cycle.
